return_stack: RTL and testbench
===============================

// Module: return_stack
// PURPOSE
//  - Hardware LIFO of return addresses, directly downstream of the call/return sequencer.
//  - Consumes Stack_EN/SP_p/SP_n/RW. Pushes the caller's return address on CALL.
//  - Pops it on RETURN and presents it to the fetch stage as the next PC.
//  - Keeps the stack pointer, full/empty status and error flags.
// PARAMETERS
//  - DEPTH  8  number of return-address entries (power of 2, >=2)
//  - WIDTH  8  return-address width in bits
// PORTS
//  - clk        in   1                 rising-edge clock
//  - rst        in   1                 asynchronous, active-high reset
//  - Stack_EN   in   1                 stack access enable from sequencer
//  - SP_p       in   1                 push request (post-increment SP)
//  - SP_n       in   1                 pop request (pre-decrement SP)
//  - RW         in   1                 1 = write (push), 0 = read (pop)
//  - din        in   WIDTH             return address to push
//  - dout       out  WIDTH             popped return address (registered)
//  - dout_valid out  1                 1-cycle pulse: dout updated by a pop
//  - sp         out  $clog2(DEPTH)+1   occupancy, 0..DEPTH
//  - full       out  1                 sp == DEPTH
//  - empty      out  1                 sp == 0
//  - overflow   out  1                 sticky: push attempted while full
//  - underflow  out  1                 sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (async, immediate): sp=0, dout=0, dout_valid=0, overflow=0, underflow=0, empty=1, full=0.
//    Memory contents are not cleared. Reset asserted mid-push/pop aborts the operation; no partial SP update.
//  - Decoded ops, sampled on posedge clk:
//      PUSH  = Stack_EN & SP_p & ~SP_n &  RW
//      POP   = Stack_EN & SP_n & ~SP_p & ~RW
//      Anything else is IDLE. This includes SP_p&SP_n together, SP_p with RW=0, SP_n with RW=1, and Stack_EN=0.
//  - PUSH, not full: mem[sp] <= din; sp <= sp+1. No dout change.
//  - PUSH, full: memory and sp unchanged; overflow <= 1.
//  - POP, not empty: dout <= mem[sp-1]; sp <= sp-1; dout_valid <= 1 for exactly one cycle.
//    Latency is 1 clock from the POP edge to valid dout.
//  - POP, empty: sp unchanged, dout holds previous value, dout_valid stays 0; underflow <= 1.
//  - IDLE: sp and dout hold; dout_valid <= 0.
//  - Back-to-back ops on consecutive cycles are legal at full rate. Push then pop returns the value just pushed.
//  - full/empty are combinational from sp. No wrap-around: sp saturates logically, and overflowing pushes are dropped.
//  - Sticky flags clear only on rst.
// CONFIGURATION
//  - Macro RETURN_STACK_ERR_EN.
//    - Defined: overflow/underflow behave as above.
//    - Undefined: both ports are tied 0 and their flops are not built. Push-when-full and pop-when-empty are still silently ignored.
// STRUCTURE
//  - Shared package stack_pkg:
//    - op encoding localparams OP_IDLE/OP_PUSH/OP_POP
//    - default DEPTH/WIDTH constants, shared with the sequencer
//  - Sub-module stack_ram: DEPTH x WIDTH register file with 1 sync write port and 1 async read port, addressed by sp / sp-1.
//  - return_stack holds op decode, sp counter, dout register, valid pulse and flags.
// TESTING
//  1. rst pulse mid-cycle while idle -> sp=0, empty=1, full=0, dout=0, dout_valid=0, flags=0 immediately, before the next clk edge.
//  2. Push 0x11, 0x22, 0x33; pop x3 -> dout 0x33, 0x22, 0x11, each with a 1-cycle dout_valid; sp 3->0; empty=1 at end.
//  3. Push 8 values 0xA0..0xA7 (DEPTH=8) -> full=1, sp=8; 9th push 0xFF -> sp=8, overflow=1 (ERR_EN); then pop -> dout=0xA7.
//  4. From empty, pop -> sp=0, dout_valid=0, dout unchanged, underflow=1 (ERR_EN) / 0 (no ERR_EN).
//  5. Illegal combos: SP_p=SP_n=1; SP_p with RW=0; SP_n with RW=1; Stack_EN=0 with SP_p=1,RW=1 -> sp, dout and memory unchanged.
//  6. Push 0x5A, then assert rst during a POP cycle -> sp=0, dout=0, no dout_valid; a subsequent pop underflows.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the call/return path: op encoding, default geometry
// and the op decoder used by the return stack.
package stack_pkg;

    // Default geometry, shared with the call/return sequencer
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    // Decoded stack operation
    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    // Decode the sequencer strobes into a single op. Any combination that is
    // not exactly a clean push or a clean pop is treated as idle.
    function automatic logic [1:0] decode_op(
        input logic stack_en,
        input logic sp_p,
        input logic sp_n,
        input logic rw
    );
        logic [1:0] op;
        op = OP_IDLE;
        if (stack_en && sp_p && !sp_n && rw) begin
            op = OP_PUSH;
        end else if (stack_en && sp_n && !sp_p && !rw) begin
            op = OP_POP;
        end else begin
            op = OP_IDLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/return_stack_if.sv
// Bundle between the call/return sequencer (master) and the return stack
// (slave): access strobes, push data, popped data and status.
interface return_stack_if #(
    parameter int DEPTH = stack_pkg::DEFAULT_DEPTH,
    parameter int WIDTH = stack_pkg::DEFAULT_WIDTH
);
    localparam int SPW = $clog2(DEPTH) + 1;

    logic             Stack_EN;
    logic             SP_p;
    logic             SP_n;
    logic             RW;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [SPW-1:0]   sp;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output Stack_EN, SP_p, SP_n, RW, din,
        input  dout, dout_valid, sp, full, empty, overflow, underflow
    );

    modport slave (
        input  Stack_EN, SP_p, SP_n, RW, din,
        output dout, dout_valid, sp, full, empty, overflow, underflow
    );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register file holding the return addresses.
// One synchronous write port, one asynchronous read port. Contents are
// deliberately not reset.
module stack_ram #(
    parameter int DEPTH = stack_pkg::DEFAULT_DEPTH,
    parameter int WIDTH = stack_pkg::DEFAULT_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write of one entry
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read of the top-of-stack entry
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses sitting behind the call/return sequencer.
// Pushes on CALL, pops on RETURN with a one-cycle dout_valid pulse, and
// tracks occupancy, full/empty and sticky error flags.
// Optional feature: define RETURN_STACK_ERR_EN to build the sticky
// overflow/underflow flags; otherwise those outputs are tied low.
module return_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic          clk,
    input logic          rst,
    return_stack_if.slave bus
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             SPW      = AW + 1;
    localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ZERO  = SPW'(0);
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
    localparam logic [AW-1:0]  ADDR_ONE = AW'(1);

    logic [1:0]       op_s;
    logic             full_s;
    logic             empty_s;
    logic             we_s;
    logic             ram_we_s;
    logic [AW-1:0]    waddr_s;
    logic [AW-1:0]    raddr_s;
    logic [WIDTH-1:0] rdata_s;

    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;

    // Op decode and occupancy status derived from the current pointer
    always_comb begin
        op_s    = decode_op(bus.Stack_EN, bus.SP_p, bus.SP_n, bus.RW);
        full_s  = (sp_q == SP_FULL);
        empty_s = (sp_q == SP_ZERO);
        waddr_s = sp_q[AW-1:0];
        raddr_s = sp_q[AW-1:0] - ADDR_ONE;
    end

    // Next pointer, dout and valid pulse; out-of-range ops are dropped
    always_comb begin
        sp_d    = sp_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        we_s    = 1'b0;
        case (op_s)
            OP_PUSH: begin
                if (!full_s) begin
                    we_s = 1'b1;
                    sp_d = sp_q + SP_ONE;
                end else begin
                    sp_d = sp_q;
                end
            end
            OP_POP: begin
                if (!empty_s) begin
                    dout_d  = rdata_s;
                    sp_d    = sp_q - SP_ONE;
                    valid_d = 1'b1;
                end else begin
                    dout_d = dout_q;
                end
            end
            default: begin
                sp_d    = sp_q;
                dout_d  = dout_q;
                valid_d = 1'b0;
            end
        endcase
    end

    // A push coinciding with reset must not leave a stray entry behind
    always_comb begin
        ram_we_s = we_s & ~rst;
    end

    // Pointer, popped data and valid pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= SP_ZERO;
            dout_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (waddr_s),
        .wdata_i (bus.din),
        .raddr_i (raddr_s),
        .rdata_o (rdata_s)
    );

`ifdef RETURN_STACK_ERR_EN
    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;

    // Sticky error flags: set on a dropped push or pop, cleared only by reset
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if ((op_s == OP_PUSH) && full_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if ((op_s == OP_POP) && empty_s) begin
            unf_d = 1'b1;
        end else begin
            unf_d = unf_q;
        end
    end

    // Error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.sp         = sp_q;
    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: a reference LIFO model plus a
// scoreboard of expected popped addresses, compared when dout_valid fires.
module tb_return_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

`ifdef RETURN_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    return_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_mis;
    logic [7:0] m_stk[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic       m_unf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        exp_q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_static(input logic exp_valid);
        check_val("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
        check_val("dout", 32'(bus.dout), 32'(m_dout));
        check_val("sp", 32'(bus.sp), 32'(m_stk.size()));
        check_val("full", 32'(bus.full), 32'(m_stk.size() == DEPTH));
        check_val("empty", 32'(bus.empty), 32'(m_stk.size() == 0));
        check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
        check_val("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    // Drive one cycle of strobes, update the model, then check after the edge
    task automatic step(input logic en, input logic p, input logic n, input logic rw,
                        input logic [7:0] d);
        logic exp_valid;
        exp_valid    = 1'b0;
        bus.Stack_EN = en;
        bus.SP_p     = p;
        bus.SP_n     = n;
        bus.RW       = rw;
        bus.din      = d;
        if (en && p && !n && rw) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(d);
            else if (ERR_EN) m_ovf = 1'b1;
        end else if (en && n && !p && !rw) begin
            if (m_stk.size() > 0) begin
                exp_q.push_back(m_stk.pop_back());
                exp_valid = 1'b1;
            end else if (ERR_EN) begin
                m_unf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.Stack_EN = 1'b0;
        bus.SP_p     = 1'b0;
        bus.SP_n     = 1'b0;
        bus.RW       = 1'b0;
        if (exp_valid && exp_q.size() > 0) m_dout = exp_q.pop_front();
        check_static(exp_valid);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic pop();
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        n_vec        = 0;
        n_mis        = 0;
        model_reset();
        rst          = 1'b1;
        bus.Stack_EN = 1'b0;
        bus.SP_p     = 1'b0;
        bus.SP_n     = 1'b0;
        bus.RW       = 1'b0;
        bus.din      = 8'h00;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        check_static(1'b0);

        // LIFO order with single-cycle valid pulses
        push(8'h11);
        push(8'h22);
        push(8'h33);
        pop();
        pop();
        pop();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Mid-cycle reset while idle takes effect before the next edge
        push(8'h44);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_static(1'b0);
        #1 rst = 1'b0;

        // Fill to DEPTH, overflow attempt, then drain
        for (int i = 0; i < DEPTH; i++) push(8'hA0 + 8'(i));
        push(8'hFF);
        for (int i = 0; i < DEPTH; i++) pop();

        // Pop from empty
        pop();

        // Illegal strobe combinations leave state and memory alone
        push(8'h11);
        push(8'h22);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hEE);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
        pop();
        pop();

        // Reset asserted during a pop aborts it
        push(8'h5A);
        bus.Stack_EN = 1'b1;
        bus.SP_n     = 1'b1;
        bus.RW       = 1'b0;
        rst          = 1'b1;
        #1;
        model_reset();
        check_static(1'b0);
        @(posedge clk);
        #1;
        check_static(1'b0);
        rst          = 1'b0;
        bus.Stack_EN = 1'b0;
        bus.SP_n     = 1'b0;
        pop();

        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
